// File: rtl/alu_pkg.sv
// Shared types and constants for the handshaked multi-cycle ALU.
// The divider path is only built when ALU_DIV_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SLL   = 4'b0011,
    OP_SUB   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_MUL   = 4'b0110,
    OP_XOR   = 4'b0111,
    OP_SLT   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_SRA   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIV   = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_REM   = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

  // Divide by zero: quotient is all ones, remainder returns the dividend.
  localparam logic DIV_BY_ZERO_Q_BIT  = 1'b1;
  localparam logic DIV_BY_ZERO_R_IS_A = 1'b1;

  function automatic logic is_mul_op(alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div_op(alu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle (ALU_DIV_EN builds only).
// The first step is folded into the start cycle so 'done' pulses XLEN-1 cycles later.
// Signed ops run on magnitudes; signs are restored on the output.
`ifdef ALU_DIV_EN
module alu_div_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic            rem_sel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] r, q, d, a_raw, a_mag, b_mag;
  logic            a_neg, b_neg, neg_q, neg_r, bz, rsel;
  logic [CW-1:0]   cnt;

  assign a_neg = is_signed & a[XLEN-1];
  assign b_neg = is_signed & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [2*XLEN-1:0] div_step(logic [XLEN-1:0] r_i, logic [XLEN-1:0] q_i,
                                                 logic [XLEN-1:0] d_i);
    logic [XLEN:0] sh, df;
    sh = {r_i, q_i[XLEN-1]};
    df = sh - {1'b0, d_i};
    if (df[XLEN]) return {sh[XLEN-1:0], q_i[XLEN-2:0], 1'b0};
    else          return {df[XLEN-1:0], q_i[XLEN-2:0], 1'b1};
  endfunction

  // Load operands with first step on start, then iterate until all bits retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0; q <= '0; d <= '0; a_raw <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; bz <= 1'b0; rsel <= 1'b0;
      cnt <= '0; busy <= 1'b0; done <= 1'b0;
    end else if (start) begin
      {r, q} <= div_step('0, a_mag, b_mag);
      d      <= b_mag;
      a_raw  <= a;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      bz     <= (b == '0);
      rsel   <= rem_sel;
      cnt    <= CW'(1);
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (busy) begin
      {r, q} <= div_step(r, q, d);
      cnt    <= cnt + CW'(1);
      if (cnt == CW'(XLEN - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  // Sign fix-up and divide-by-zero override; min/-1 overflow falls out naturally.
  always_comb begin
    if (bz)        res = rsel ? (DIV_BY_ZERO_R_IS_A ? a_raw : '0) : {XLEN{DIV_BY_ZERO_Q_BIT}};
    else if (rsel) res = neg_r ? -r : r;
    else           res = neg_q ? -q : q;
  end

endmodule
`endif

// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle RV32-style ALU (EX stage).
// Single-cycle ops complete at the accept edge; MUL/MULHU use a shift-add
// iterator retiring MUL_STEP bits/cycle. Define ALU_DIV_EN to build the
// divider; otherwise DIV/DIVU/REM/REMU report illegal with result 0.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam int SHW       = $clog2(XLEN);
  localparam int MUL_ITERS = XLEN / MUL_STEP;
  localparam int MCW       = $clog2(MUL_ITERS);
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  alu_state_e               state, state_nx;
  alu_op_e                  op_in, op_q;
  logic                     accept, is_mul_in, is_div_in, mul_last;
  logic [XLEN-1:0]          mcand, sc_res, div_res, res_nx;
  logic [2*XLEN-1:0]        prod, prod_nx;
  logic [MCW-1:0]           mul_cnt;
  logic [XLEN+MUL_STEP-1:0] mul_sum;
  logic                     ill_nx, ld_res, div_done, div_busy;
  logic [SHW-1:0]           shamt;

  assign op_in     = alu_op_e'(alu_op);
  assign is_mul_in = is_mul_op(op_in);
  assign is_div_in = is_div_op(op_in);
  assign accept    = in_valid && in_ready;
  assign shamt     = op_b[SHW-1:0];
  assign mul_last  = (state == MUL) && (mul_cnt == MCW'(MUL_ITERS - 1));

  // Handshake outputs decoded from state.
  always_comb begin
    out_valid = (state == DONE);
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  end

  // Next-state: DONE doubles as an issue slot so results can stream back to back.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (is_mul_in)                state_nx = MUL;
          else if (is_div_in && DIV_EN) state_nx = DIV;
          else                          state_nx = DONE;
        end else if ((state == DONE) && out_ready) begin
          state_nx = IDLE;
        end
      end
      MUL:     if (mul_last) state_nx = DONE;
      DIV:     if (div_done && !div_busy) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Single-cycle datapath straight off the input port; unsupported codes give 0.
  always_comb begin
    sc_res = '0;
    case (op_in)
      OP_AND:  sc_res = op_a & op_b;
      OP_OR:   sc_res = op_a | op_b;
      OP_XOR:  sc_res = op_a ^ op_b;
      OP_ADD:  sc_res = op_a + op_b;
      OP_SUB:  sc_res = op_a - op_b;
      OP_SLL:  sc_res = op_a << shamt;
      OP_SRL:  sc_res = op_a >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  sc_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: sc_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      default: sc_res = '0;
    endcase
  end

  // Shift-add step: add mcand * low multiplier bits into the high half, shift right.
  always_comb begin
    mul_sum = {{MUL_STEP{1'b0}}, prod[2*XLEN-1:XLEN]}
            + ({{MUL_STEP{1'b0}}, mcand} * {{XLEN{1'b0}}, prod[MUL_STEP-1:0]});
    prod_nx = {mul_sum, prod[XLEN-1:MUL_STEP]};
  end

  // Multiplier state; operands and opcode are captured on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod    <= '0;
      mcand   <= '0;
      mul_cnt <= '0;
      op_q    <= OP_AND;
    end else if (accept) begin
      op_q    <= op_in;
      mcand   <= op_a;
      prod    <= {{XLEN{1'b0}}, op_b};
      mul_cnt <= '0;
    end else if (state == MUL) begin
      prod    <= prod_nx;
      mul_cnt <= mul_cnt + MCW'(1);
    end
  end

`ifdef ALU_DIV_EN
  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && is_div_in),
    .is_signed ((op_in == OP_DIV) || (op_in == OP_REM)),
    .rem_sel   ((op_in == OP_REM) || (op_in == OP_REMU)),
    .a         (op_a),
    .b         (op_b),
    .busy      (div_busy),
    .done      (div_done),
    .res       (div_res)
  );
`else
  assign div_busy = 1'b0;
  assign div_done = 1'b0;
  assign div_res  = '0;
`endif

  // Pick which unit's result lands in the output register this cycle.
  always_comb begin
    ld_res = 1'b0;
    res_nx = sc_res;
    ill_nx = 1'b0;
    if (accept && !is_mul_in && !(is_div_in && DIV_EN)) begin
      ld_res = 1'b1;
      res_nx = sc_res;
      ill_nx = is_div_in && !DIV_EN;
    end else if (mul_last) begin
      ld_res = 1'b1;
      res_nx = (op_q == OP_MULHU) ? prod_nx[2*XLEN-1:XLEN] : prod_nx[XLEN-1:0];
    end else if ((state == DIV) && div_done) begin
      ld_res = 1'b1;
      res_nx = div_res;
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else if (ld_res) begin
      result  <= res_nx;
      zero    <= (res_nx == '0);
      illegal <= ill_nx;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (XLEN=32, MUL_STEP=1).
// Expected DIV/REM behaviour follows ALU_DIV_EN like the design.
`timescale 1ns/1ps
module tb_alu_multicycle;
  localparam int XLEN = 32;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            in_valid = 1'b0, out_ready = 1'b0;
  logic            in_ready, out_valid, zero, illegal;
  logic [3:0]      alu_op = 4'd0;
  logic [XLEN-1:0] op_a = '0, op_b = '0, result;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0, nerr = 0, cyc = 0;
  bit   seen = 1'b0, rnd = 1'b0;

  alu_multicycle #(.XLEN(XLEN), .MUL_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model of the ALU.
  function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    int sa, sbb;
    e.res = '0; e.ill = 1'b0; e.lat = 1; e.acc = 0;
    sa = a; sbb = b;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  e.res = a + b;
      4'd4:  e.res = a - b;
      4'd7:  e.res = a ^ b;
      4'd3:  e.res = a << b[4:0];
      4'd5:  e.res = a >> b[4:0];
      4'd10: e.res = $signed(a) >>> b[4:0];
      4'd8:  e.res = (sa < sbb) ? 32'd1 : 32'd0;
      4'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd6:  begin e.res = p[31:0];  e.lat = 33; end
      4'd11: begin e.res = p[63:32]; e.lat = 33; end
      default: begin
`ifdef ALU_DIV_EN
        e.lat = 33;
        if (b == 0)                                   e.res = (op[1]) ? a : 32'hFFFF_FFFF;
        else if (op == 4'd12 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = 32'h8000_0000;
        else if (op == 4'd14 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = 32'd0;
        else if (op == 4'd12)                         e.res = sa / sbb;
        else if (op == 4'd14)                         e.res = sa % sbb;
        else if (op == 4'd13)                         e.res = a / b;
        else                                          e.res = a % b;
`else
        e.res = '0; e.ill = 1'b1;
`endif
      end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Drive one request starting at a negedge; returns at the negedge after the accept.
  task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    int w = 0;
    in_valid = 1'b1; alu_op = op; op_a = a; op_b = b;
    #1;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      #1;
      w++;
    end
    if (w >= 300) begin
      chk("issue_timeout", in_ready, 1);
    end else begin
      e = model(op, a, b);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Output monitor: checks every cycle out_valid is high (covers the hold case).
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        if (!seen) begin
          chk("latency", cyc - sb[0].acc + 1, sb[0].lat);
          seen = 1'b1;
        end
        chk("result", result, sb[0].res);
        chk("zero", zero, sb[0].zero);
        chk("illegal", illegal, sb[0].ill);
        if (out_ready) begin
          sb.delete(0);
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [3:0]  d_op[20] = '{4'd2, 4'd10, 4'd8, 4'd9, 4'd6, 4'd11, 4'd12, 4'd14, 4'd12, 4'd12,
                            4'd0, 4'd1, 4'd4, 4'd3, 4'd5, 4'd13, 4'd15, 4'd12, 4'd14, 4'd6};
  logic [31:0] d_a[20]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'h8000_0000,
                            32'd7, 32'hF0F0_1234, 32'h0F00_00F0, 32'd5, 32'h0000_0003,
                            32'h8000_0000, 32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'h1234_5678};
  logic [31:0] d_b[20]  = '{32'd1, 32'h21, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'd2, 32'hFF00_FF00, 32'h00F0_0F00, 32'd9,
                            32'h0000_0024, 32'h0000_001F, 32'd7, 32'd7, 32'd2, 32'd2,
                            32'h9ABC_DEF0};

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready, 1);
    out_ready = 1'b1;
    @(negedge clk);

    // Directed ops, issued back to back.
    for (int i = 0; i < 20; i++) issue(d_op[i], d_a[i], d_b[i]);
    drain();

    // Backpressure: result must hold and input must stall.
    out_ready = 1'b0;
    issue(4'd2, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", result, 7);
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue(4'd7, 32'h0000_F0F0, 32'h0000_0FF0);
    drain();

    // Reset in the middle of a multiply.
    issue(4'd7, 32'd5, 32'd3);
    drain();
    issue(4'd6, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_zero", zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    issue(4'd2, 32'd1, 32'd1);
    drain();

    // Random ops with random consumer stalls.
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      issue(4'($urandom_range(0, 15)), pick(), pick());
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rnd = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
